// File: rtl/sync_queue_deq_narrower_if.sv
// Wide-in / narrow-out stream bundle for sync_queue_deq_narrower.
// master = upstream queue plus downstream consumer; slave = the narrower itself.
interface sync_queue_deq_narrower_if #(
   parameter int IN_W  = 128,
   parameter int OUT_W = 32
);
   localparam int BEATS = IN_W / OUT_W;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   // Each side transfers on a cycle where valid and ready are both high.
   // A producer holds valid and payload until that cycle.
   // valid never waits on ready; ready may depend combinationally on the other side.
   logic             io_enq_ready;
   logic             io_enq_valid;
   logic [IN_W-1:0]  io_enq_bits;
   logic             io_deq_ready;
   logic             io_deq_valid;
   logic [OUT_W-1:0] io_deq_bits;
   logic             io_deq_last;
   logic [CNT_W-1:0] io_deq_idx;

   modport master (
      input  io_enq_ready,
      output io_enq_valid,
      output io_enq_bits,
      output io_deq_ready,
      input  io_deq_valid,
      input  io_deq_bits,
      input  io_deq_last,
      input  io_deq_idx
   );

   modport slave (
      output io_enq_ready,
      input  io_enq_valid,
      input  io_enq_bits,
      input  io_deq_ready,
      output io_deq_valid,
      output io_deq_bits,
      output io_deq_last,
      output io_deq_idx
   );
endinterface

// File: rtl/sync_queue_deq_narrower.sv
// Splits each wide dequeued word into BEATS narrow beats, least-significant slice first.
// The next word loads in the same cycle the last beat of the current word is taken.
module sync_queue_deq_narrower #(
   parameter int IN_W  = 128,
   parameter int OUT_W = 32
) (
   input  logic                      clock,
   input  logic                      reset,
   sync_queue_deq_narrower_if.slave  bus,
   output logic                      o_dbg_state
);
   localparam int BEATS = IN_W / OUT_W;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

   typedef enum logic {ST_EMPTY = 1'b0, ST_HOLD = 1'b1} state_e;

   state_e           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [IN_W-1:0]  r_data;

   state_e           w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_load;
   logic             w_full;
   logic             w_last;
   logic             w_enq_fire;
   logic             w_deq_fire;
   logic [OUT_W-1:0] w_slices [BEATS];

   assign w_full     = (r_state == ST_HOLD);
   assign w_last     = w_full & (r_cnt == LAST_IDX);
   assign w_enq_fire = bus.io_enq_valid & bus.io_enq_ready;
   assign w_deq_fire = bus.io_deq_valid & bus.io_deq_ready;

   always_comb begin
      for (int i = 0; i < BEATS; i++) begin
         w_slices[i] = r_data[i*OUT_W +: OUT_W];
      end
   end

   // Ready is open when empty, or when the final beat leaves this cycle.
   assign bus.io_enq_ready = ~w_full | (bus.io_deq_ready & w_last);
   assign bus.io_deq_valid = w_full;
   assign bus.io_deq_bits  = w_slices[r_cnt];
   assign bus.io_deq_idx   = r_cnt;
   assign bus.io_deq_last  = w_last;
   assign o_dbg_state      = r_state;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_load      = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_enq_fire) begin
               w_load      = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (w_deq_fire) begin
               if (w_last) begin
                  w_cnt_nxt = '0;
                  // A waiting word is taken now so beats continue without a bubble.
                  if (w_enq_fire) begin
                     w_load = 1'b1;
                  end else begin
                     w_state_nxt = ST_EMPTY;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_EMPTY;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= ST_EMPTY;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_data <= '0;
      end else if (w_load) begin
         r_data <= bus.io_enq_bits;
      end
   end
endmodule

// File: tb/tb_sync_queue_deq_narrower.sv
// Directed and randomised checks of the 128-to-32 dequeue narrower.
module tb_sync_queue_deq_narrower;
   localparam int IN_W  = 128;
   localparam int OUT_W = 32;
   localparam int BEATS = IN_W / OUT_W;
   localparam int N_WORDS = 1000;
   localparam int MAX_CYC = 20000;

   logic clock;
   logic reset;
   logic dbg_state;

   int n_vec = 0;
   int n_err = 0;

   logic [OUT_W-1:0] exp_q[$];

   sync_queue_deq_narrower_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

   sync_queue_deq_narrower #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
      .clock       (clock),
      .reset       (reset),
      .bus         (bus.slave),
      .o_dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic look();
      @(negedge clock);
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
      n_vec++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic expect_beat(input string tag, input logic [31:0] bits, input int idx);
      check({tag, ".valid"}, bus.io_deq_valid, 1'b1);
      check({tag, ".bits"},  bus.io_deq_bits, bits);
      check({tag, ".idx"},   bus.io_deq_idx, idx);
      check({tag, ".last"},  bus.io_deq_last, (idx == BEATS - 1));
   endtask

   function automatic logic [31:0] slice(input logic [127:0] w, input int i);
      return w[i*OUT_W +: OUT_W];
   endfunction

   // ---------------- directed sequence + scoreboard ----------------
   initial begin
      logic [127:0] w_a, w_b, w_c, w_d, w_e, w_f, w_cur;
      logic [31:0]  single_exp [4];
      int words_sent, beat_idx, cyc;
      logic enq_f, deq_f;

      w_a = 128'h33333333_22222222_11111111_00000000;
      w_b = 128'h77777777_66666666_55555555_44444444;
      w_c = 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000;
      w_d = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
      w_e = 128'h0E0E0E03_0E0E0E02_0E0E0E01_0E0E0E00;
      w_f = 128'hF0000003_F0000002_F0000001_F0000000;
      single_exp[0] = 32'h00000000;
      single_exp[1] = 32'h11111111;
      single_exp[2] = 32'h22222222;
      single_exp[3] = 32'h33333333;

      reset = 1'b0;
      bus.io_enq_valid = 1'b0;
      bus.io_enq_bits  = '0;
      bus.io_deq_ready = 1'b0;

      // reset state
      tick();
      tick();
      look();
      check("rst.valid", bus.io_deq_valid, 1'b0);
      check("rst.last",  bus.io_deq_last, 1'b0);
      check("rst.idx",   bus.io_deq_idx, 0);
      check("rst.bits",  bus.io_deq_bits, 0);
      check("rst.state", dbg_state, 1'b0);
      tick();
      reset = 1'b1;
      look();
      check("rel.enq_ready", bus.io_enq_ready, 1'b1);

      // single word
      tick();
      bus.io_enq_valid = 1'b1;
      bus.io_enq_bits  = w_a;
      bus.io_deq_ready = 1'b1;
      look();
      check("single.enq_ready", bus.io_enq_ready, 1'b1);
      check("single.pre_valid", bus.io_deq_valid, 1'b0);
      tick();
      bus.io_enq_valid = 1'b0;
      bus.io_enq_bits  = '0;
      for (int i = 0; i < BEATS; i++) begin
         look();
         expect_beat("single", single_exp[i], i);
         check("single.state", dbg_state, 1'b1);
         tick();
      end
      look();
      check("single.after_valid", bus.io_deq_valid, 1'b0);

      // back-to-back: second word enters as the first word's last beat leaves
      tick();
      bus.io_enq_valid = 1'b1;
      bus.io_enq_bits  = w_a;
      tick();
      bus.io_enq_bits = w_b;
      for (int i = 0; i < BEATS; i++) begin
         look();
         expect_beat("b2b.w0", slice(w_a, i), i);
         check("b2b.enq_ready", bus.io_enq_ready, (i == BEATS - 1));
         tick();
      end
      bus.io_enq_valid = 1'b0;
      for (int i = 0; i < BEATS; i++) begin
         look();
         expect_beat("b2b.w1", slice(w_b, i), i);
         tick();
      end
      look();
      check("b2b.after_valid", bus.io_deq_valid, 1'b0);

      // backpressure at idx 2, with a competing word offered that must be refused
      tick();
      bus.io_enq_valid = 1'b1;
      bus.io_enq_bits  = w_c;
      tick();
      bus.io_enq_valid = 1'b0;
      look();
      expect_beat("bp.b0", slice(w_c, 0), 0);
      tick();
      look();
      expect_beat("bp.b1", slice(w_c, 1), 1);
      tick();
      bus.io_deq_ready = 1'b0;
      bus.io_enq_valid = 1'b1;
      bus.io_enq_bits  = w_d;
      for (int i = 0; i < 5; i++) begin
         look();
         expect_beat("bp.stall", slice(w_c, 2), 2);
         check("bp.enq_ready", bus.io_enq_ready, 1'b0);
         tick();
      end
      bus.io_deq_ready = 1'b1;
      bus.io_enq_valid = 1'b0;
      look();
      expect_beat("bp.resume", slice(w_c, 2), 2);
      tick();
      look();
      expect_beat("bp.b3", slice(w_c, 3), 3);
      tick();

      // drain to empty
      look();
      check("drain.valid", bus.io_deq_valid, 1'b0);
      check("drain.enq_ready", bus.io_enq_ready, 1'b1);
      check("drain.idx", bus.io_deq_idx, 0);
      tick();
      bus.io_enq_valid = 1'b1;
      bus.io_enq_bits  = w_e;
      tick();
      bus.io_enq_valid = 1'b0;
      look();
      expect_beat("drain.next_b0", slice(w_e, 0), 0);
      tick();
      look();
      expect_beat("drain.next_b1", slice(w_e, 1), 1);

      // reset mid-word at idx 1
      #1;
      reset = 1'b0;
      #1;
      check("rstmid.valid", bus.io_deq_valid, 1'b0);
      check("rstmid.bits",  bus.io_deq_bits, 0);
      check("rstmid.idx",   bus.io_deq_idx, 0);
      tick();
      check("rstmid.hold_valid", bus.io_deq_valid, 1'b0);
      check("rstmid.hold_bits",  bus.io_deq_bits, 0);
      reset = 1'b1;
      bus.io_enq_valid = 1'b1;
      bus.io_enq_bits  = w_f;
      look();
      check("rstmid.enq_ready", bus.io_enq_ready, 1'b1);
      check("rstmid.no_old", bus.io_deq_valid, 1'b0);
      tick();
      bus.io_enq_valid = 1'b0;
      for (int i = 0; i < BEATS; i++) begin
         look();
         expect_beat("rstmid.new", slice(w_f, i), i);
         tick();
      end
      look();
      check("rstmid.after_valid", bus.io_deq_valid, 1'b0);

      // random stress against the scoreboard
      words_sent = 0;
      beat_idx   = 0;
      cyc        = 0;
      w_cur      = {$urandom, $urandom, $urandom, $urandom};
      while ((words_sent < N_WORDS || exp_q.size() != 0) && cyc < MAX_CYC) begin
         tick();
         cyc++;
         bus.io_enq_valid = (words_sent < N_WORDS) && ($urandom_range(0, 3) != 0);
         bus.io_enq_bits  = w_cur;
         bus.io_deq_ready = ($urandom_range(0, 3) != 0);
         look();
         enq_f = bus.io_enq_valid & bus.io_enq_ready;
         deq_f = bus.io_deq_valid & bus.io_deq_ready;
         if (deq_f) begin
            if (exp_q.size() == 0) begin
               check("stress.spurious_beat", bus.io_deq_valid, 1'b0);
            end else begin
               check("stress.bits", bus.io_deq_bits, exp_q.pop_front());
               check("stress.idx",  bus.io_deq_idx, beat_idx);
               check("stress.last", bus.io_deq_last, (beat_idx == BEATS - 1));
               beat_idx = (beat_idx + 1) % BEATS;
            end
         end
         if (enq_f) begin
            for (int i = 0; i < BEATS; i++) exp_q.push_back(slice(w_cur, i));
            words_sent++;
            w_cur = {$urandom, $urandom, $urandom, $urandom};
         end
      end
      check("stress.timeout", (cyc < MAX_CYC), 1'b1);
      check("stress.words", words_sent, N_WORDS);
      check("stress.leftover", exp_q.size(), 0);

      // final report
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
